// File: rtl/state_report_pkg.sv
// Shared constants and FSM encoding for the settings read-back transmitter.
// The frame is "f" + four digits, optionally followed by CR LF.
package state_report_pkg;

  localparam logic [7:0] CH_F  = 8'h66;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_Q  = 8'h3F;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  localparam int FRAME_LEN_SHORT = 5;
  localparam int FRAME_LEN_LONG  = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/digit_to_ascii.sv
// Encodes one settings field as a single ASCII digit '1'..'9'.
// Zero and anything above nine become '?', matching what the parser rejects.
module digit_to_ascii
  import state_report_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] i_val,
  output logic [7:0]   o_char,
  output logic         o_invalid
);

  always_comb begin
    o_invalid = (i_val == '0) || (i_val > W'(9));
    o_char    = o_invalid ? CH_Q : (CH_0 + 8'(i_val));
  end

endmodule

// File: rtl/state_report_tx.sv
// Snapshots the current settings and streams them to the UART transmitter as
// an ASCII frame. Triggered by a host request or an optional periodic timer.
module state_report_tx
  import state_report_pkg::*;
#(
  parameter bit SEND_CRLF   = 1'b1,
  parameter int AUTO_PERIOD = 0,
  parameter int PERIOD_W    = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_report_req,
  input  logic [4:0] i_state,
  input  logic [7:0] i_state_freq,
  input  logic [7:0] i_state_amp,
  input  logic [7:0] i_state_phase,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  output logic       o_report_busy,
  output logic       o_report_done,
  output logic       o_fmt_err,
  output state_e     o_dbg_state
);

  // Valid/ready: a byte moves on any edge where o_tx_valid && i_tx_ready; while
  // valid is high and ready is low, o_tx_data and o_tx_valid hold unchanged.

  localparam logic [2:0] LAST_IDX = SEND_CRLF ? 3'(FRAME_LEN_LONG - 1)
                                              : 3'(FRAME_LEN_SHORT - 1);
  localparam logic [PERIOD_W-1:0] PERIOD_LAST =
    (AUTO_PERIOD > 0) ? PERIOD_W'(AUTO_PERIOD - 1) : '0;

  state_e              r_state;
  logic [2:0]          r_idx;
  logic                r_pending;
  logic [7:0]          r_dig [4];
  logic [7:0]          r_data;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic                r_fmt_err;
  logic [PERIOD_W-1:0] r_period_cnt;

  logic [7:0] w_chr [4];
  logic [3:0] w_inv;
  logic       w_tick;
  logic       w_new_trig;
  logic       w_trigger;
  logic [2:0] w_idx_next;
  logic [7:0] w_next_byte;

  digit_to_ascii #(.W(5)) u_dig_state (.i_val(i_state),       .o_char(w_chr[0]), .o_invalid(w_inv[0]));
  digit_to_ascii #(.W(8)) u_dig_freq  (.i_val(i_state_freq),  .o_char(w_chr[1]), .o_invalid(w_inv[1]));
  digit_to_ascii #(.W(8)) u_dig_amp   (.i_val(i_state_amp),   .o_char(w_chr[2]), .o_invalid(w_inv[2]));
  digit_to_ascii #(.W(8)) u_dig_phase (.i_val(i_state_phase), .o_char(w_chr[3]), .o_invalid(w_inv[3]));

  assign w_tick     = (AUTO_PERIOD > 0) && (r_period_cnt == PERIOD_LAST);
  assign w_new_trig = i_report_req | w_tick;
  assign w_trigger  = w_new_trig | r_pending;
  assign w_idx_next = r_idx + 3'd1;

  // The snapshot stores already-encoded characters, so the frame cannot change
  // once captured regardless of what the inputs do.
  always_comb begin
    w_next_byte = CH_F;
    case (w_idx_next)
      3'd1:    w_next_byte = r_dig[0];
      3'd2:    w_next_byte = r_dig[1];
      3'd3:    w_next_byte = r_dig[2];
      3'd4:    w_next_byte = r_dig[3];
      3'd5:    w_next_byte = CH_CR;
      3'd6:    w_next_byte = CH_LF;
      default: w_next_byte = CH_F;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if (w_tick) begin
      r_period_cnt <= '0;
    end else if (AUTO_PERIOD > 0) begin
      r_period_cnt <= r_period_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_dig     <= '{default: '0};
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_fmt_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_dig     <= w_chr;
            r_fmt_err <= |w_inv;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_data    <= CH_F;
            r_valid   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= SEND;
          end
        end
        SEND: begin
          if (w_new_trig) r_pending <= 1'b1;
          if (r_valid && i_tx_ready) begin
            r_idx <= w_idx_next;
            if (r_idx == LAST_IDX) begin
              r_valid <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_data <= w_next_byte;
            end
          end
        end
        DONE: begin
          if (w_new_trig) r_pending <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_tx_data     = r_data;
  assign o_tx_valid    = r_valid;
  assign o_report_busy = r_busy;
  assign o_report_done = r_done;
  assign o_fmt_err     = r_fmt_err;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_state_report_tx.sv
// Bench for state_report_tx: a CRLF instance under directed stimulus with a
// byte/fmt scoreboard, plus a short-frame instance with a 100-cycle auto period.
module tb_state_report_tx;
  import state_report_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst2_n = 1'b0;
  logic       report_req = 1'b0;
  logic [4:0] st = '0;
  logic [7:0] freq = '0, amp = '0, phase = '0;
  logic       tx_ready = 1'b1;
  logic       tx2_ready = 1'b1;
  logic       req2 = 1'b0;

  logic [7:0] tx_data, tx2_data;
  logic       tx_valid, busy, done, fmt_err;
  logic       tx2_valid, busy2, done2, fmt_err2;
  state_e     dbg_state, dbg2_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic       fmt_q[$];

  state_report_tx #(.SEND_CRLF(1'b1), .AUTO_PERIOD(0), .PERIOD_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_report_req(report_req),
    .i_state(st), .i_state_freq(freq), .i_state_amp(amp), .i_state_phase(phase),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_report_busy(busy), .o_report_done(done), .o_fmt_err(fmt_err),
    .o_dbg_state(dbg_state)
  );

  state_report_tx #(.SEND_CRLF(1'b0), .AUTO_PERIOD(100), .PERIOD_W(8)) dut2 (
    .clk(clk), .rst_n(rst2_n), .i_report_req(req2),
    .i_state(5'd2), .i_state_freq(8'd4), .i_state_amp(8'd6), .i_state_phase(8'd8),
    .o_tx_data(tx2_data), .o_tx_valid(tx2_valid), .i_tx_ready(tx2_ready),
    .o_report_busy(busy2), .o_report_done(done2), .o_fmt_err(fmt_err2),
    .o_dbg_state(dbg2_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    tick();
    report_req = 1'b0;
  endtask

  task automatic push_frame(input logic [7:0] d0, d1, d2, d3, input logic fmt);
    exp_q.push_back(CH_F);
    exp_q.push_back(d0);
    exp_q.push_back(d1);
    exp_q.push_back(d2);
    exp_q.push_back(d3);
    exp_q.push_back(CH_CR);
    exp_q.push_back(CH_LF);
    fmt_q.push_back(fmt);
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || fmt_q.size() != 0 || busy) && n < max_cyc) begin
      tick();
      n++;
    end
    check(name, 32'(n < max_cyc), 32'd1);
  endtask

  // Monitor: every accepted byte and every done pulse is popped and compared.
  always @(negedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL tx_byte_extra: got %0h, required no byte", tx_data);
      end else begin
        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
    if (rst_n && done) begin
      if (fmt_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL done_extra: got report_done=1, required 0");
      end else begin
        check("fmt_err_at_done", 32'(fmt_err), 32'(fmt_q.pop_front()));
      end
    end
  end

  logic [7:0] pat2 [5] = '{8'h66, 8'h32, 8'h34, 8'h36, 8'h38};
  int pos2 = 0, frames2 = 0, last2 = 0;
  bit have2 = 1'b0;

  always @(negedge clk) begin
    if (rst2_n && tx2_valid) begin
      check("auto_byte", 32'(tx2_data), 32'(pat2[pos2]));
      if (pos2 == 0) begin
        if (have2) check("auto_period", 32'(cyc - last2), 32'd100);
        last2 = cyc;
        have2 = 1'b1;
      end
      if (pos2 == 4) begin
        pos2 = 0;
        frames2++;
      end else begin
        pos2++;
      end
    end
  end

  initial begin
    int nv;
    #23;
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fmt_err", 32'(fmt_err), 32'd0);
    check("rst_fsm", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    rst2_n = 1'b1;
    tick();

    // Test 1: basic frame with consecutive bytes, latency 1
    st = 5'd3; freq = 8'd1; amp = 8'd1; phase = 8'd1; tx_ready = 1'b1;
    push_frame(8'h33, 8'h31, 8'h31, 8'h31, 1'b0);
    pulse_req();
    check("t1_first_valid", 32'(tx_valid), 32'd1);
    check("t1_first_byte", 32'(tx_data), 32'h66);
    nv = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_valid) nv++;
    end
    check("t1_consecutive_valid", 32'(nv), 32'd7);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_valid_dropped", 32'(tx_valid), 32'd0);
    tick();
    check("t1_done_one_cycle", 32'(done), 32'd0);
    wait_idle(40, "t1_idle");

    // Test 2: back-pressure while byte 2 is presented
    push_frame(8'h33, 8'h31, 8'h31, 8'h31, 1'b0);
    pulse_req();
    tick();
    tick();
    tx_ready = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_valid && tx_data == 8'h31) nv++;
    end
    check("t2_held_cycles", 32'(nv), 32'd10);
    tx_ready = 1'b1;
    wait_idle(40, "t2_idle");

    // Test 3: out-of-range fields, then a clean frame clears fmt_err
    st = 5'd9; freq = 8'd0; amp = 8'd12; phase = 8'd5;
    push_frame(8'h39, 8'h3F, 8'h3F, 8'h35, 1'b1);
    pulse_req();
    wait_idle(40, "t3a_idle");
    check("t3_fmt_err_held", 32'(fmt_err), 32'd1);
    st = 5'd3; freq = 8'd1; amp = 8'd1; phase = 8'd1;
    push_frame(8'h33, 8'h31, 8'h31, 8'h31, 1'b0);
    pulse_req();
    wait_idle(40, "t3b_idle");
    check("t3_fmt_err_cleared", 32'(fmt_err), 32'd0);

    // Test 4: snapshot holds; two mid-frame requests collapse into one frame
    push_frame(8'h33, 8'h31, 8'h31, 8'h31, 1'b0);
    push_frame(8'h37, 8'h31, 8'h31, 8'h31, 1'b0);
    pulse_req();
    tick();
    tick();
    st = 5'd7;
    pulse_req();
    tick();
    pulse_req();
    wait_idle(60, "t4_idle");
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_valid) nv++;
    end
    check("t4_no_third_frame", 32'(nv), 32'd0);

    // Test 6: reset during byte 3 aborts the frame without a done pulse
    st = 5'd4; freq = 8'd2; amp = 8'd3; phase = 8'd9;
    push_frame(8'h34, 8'h32, 8'h33, 8'h39, 1'b0);
    pulse_req();
    tick();
    tick();
    tick();
    check("t6_byte3_presented", 32'(tx_data), 32'h33);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid_drop", 32'(tx_valid), 32'd0);
    check("t6_async_busy_drop", 32'(busy), 32'd0);
    exp_q.delete();
    fmt_q.delete();
    nv = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) nv++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done || tx_valid) nv++;
    end
    check("t6_no_done_no_valid", 32'(nv), 32'd0);
    push_frame(8'h34, 8'h32, 8'h33, 8'h39, 1'b0);
    pulse_req();
    check("t6_restart_f", 32'(tx_data), 32'h66);
    wait_idle(40, "t6_idle");

    // Test 5: the auto-period instance must have produced at least three frames
    nv = 0;
    while (frames2 < 3 && nv < 400) begin
      tick();
      nv++;
    end
    check("t5_auto_frames", 32'(frames2 >= 3), 32'd1);
    check("t5_fmt_err2", 32'(fmt_err2), 32'd0);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("fmt_q_drained", 32'(fmt_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/state_report_tx.md
Name: state_report_tx

Overview:
- Transmit-side counterpart of the ASCII command parser.
- Snapshots the current state/freq/amp/phase settings and serialises them as an ASCII frame "f" + 4 digits (+ optional CR LF), one byte at a time, into the UART transmitter.
- Fired by a host-request pulse or an optional periodic timer; lets the host read back the settings it wrote with the same "f" + 4-digit format.

Parameters:
- SEND_CRLF, 1, 1: frame is 7 bytes (f d d d d CR LF); 0: frame is 5 bytes (f d d d d).
- AUTO_PERIOD, 0, clock cycles between automatic reports; 0 disables periodic reporting.
- PERIOD_W, 32, width of the periodic counter; must hold AUTO_PERIOD.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- report_req  in  1  one-cycle request to send a report
- state  in  5  current state value
- state_freq  in  8  current frequency selector
- state_amp  in  8  current amplitude selector
- state_phase  in  8  current phase selector
- tx_data  out  8  byte to the UART transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  UART transmitter accepts a byte
- report_busy  out  1  frame in progress
- report_done  out  1  one-cycle pulse after the last byte is accepted
- fmt_err  out  1  last captured frame contained an out-of-range field

Behaviour:
- Reset (asynchronous, while rst_n=0):
  - tx_data=0, tx_valid=0, report_busy=0, report_done=0, fmt_err=0.
  - FSM goes to IDLE; pending flag, byte index, period counter and snapshot are cleared.
- FSM states:
  - IDLE: wait for a trigger.
  - SEND: present bytes to the UART transmitter.
  - DONE: one-cycle completion state.
- Trigger: report_req=1, or periodic tick (counter reaches AUTO_PERIOD-1 and wraps to 0; active only when AUTO_PERIOD>0), or pending flag set.
- IDLE, trigger sampled at edge k:
  - At edge k: snapshot all four inputs, index=0, fmt_err updated, go SEND, pending cleared.
  - tx_valid=1 with tx_data='f' (0x66) in cycle k+1. Latency is 1 cycle.
- SEND:
  - tx_valid=1; tx_data is the byte at the current index; both held stable until tx_valid && tx_ready.
  - On the handshake edge: index increments. If the last byte was accepted, go DONE and drop tx_valid.
  - Byte order: 0x66, digit(state), digit(freq), digit(amp), digit(phase), then 0x0D, 0x0A if SEND_CRLF=1.
- DONE: report_done=1 for exactly one cycle, then IDLE. report_busy=1 in SEND and DONE.
- Digit encoding:
  - Value v in 1..9 encodes as 8'd48 + v, i.e. '1'..'9'. This matches the parser, which rejects '0'.
  - v=0 or v>9 (state width 5, others width 8, compared at full width) encodes as '?' (0x3F).
  - fmt_err is set at capture if any field is invalid, cleared at capture if all are valid, and held between captures.
- Triggers while report_busy=1:
  - Set a one-deep pending flag; multiple triggers collapse into one.
  - After DONE, IDLE sees pending and starts a fresh frame, with a fresh snapshot, on the next edge.
- Simultaneous report_req and periodic tick: one frame.
- Input changes mid-frame do not affect the current frame (snapshot).
- Back-pressure: tx_ready may stay low indefinitely; no timeout, no byte dropped or repeated.
- Period counter free-runs, including during a frame; a tick during a frame becomes pending.
- Reset mid-frame: frame aborted immediately, no report_done; the next trigger sends a full frame from 'f'.

Decomposition:
- Package state_report_pkg holds:
  - ASCII constants: CH_F=8'h66, CH_0=8'h30, CH_Q=8'h3F, CH_CR=8'h0D, CH_LF=8'h0A.
  - FSM state encoding: IDLE, SEND, DONE.
  - Frame length constants: 5 and 7.
- One natural sub-module: digit_to_ascii. Combinational, with parameter W (input width); outputs the ASCII byte and an invalid flag. Instantiated four times (W=5, 8, 8, 8).

Test Plan:
1. Basic frame: state=3, freq=1, amp=1, phase=1, tx_ready=1, one report_req → bytes 0x66, 0x33, 0x31, 0x31, 0x31, 0x0D, 0x0A on 7 consecutive cycles starting the cycle after req; report_done one cycle later; fmt_err=0.
2. Back-pressure: tx_ready low for 10 cycles while byte 2 (0x31) is presented → tx_valid and tx_data held stable for all 10 cycles; full 7-byte frame delivered with no loss or duplication.
3. Invalid fields: freq=0, amp=12, state=9, phase=5 → bytes 0x66, 0x39, 0x3F, 0x3F, 0x35, 0x0D, 0x0A; fmt_err=1; a following valid frame clears fmt_err.
4. Snapshot and pending: start a frame with state=3; at byte 2 change state to 7 and pulse report_req twice → first frame carries 0x33; exactly one further frame follows, carrying 0x37.
5. Parameter variants: AUTO_PERIOD=100, SEND_CRLF=0, tx_ready=1 → 5-byte frames ('f' + 4 digits) starting every 100 clocks, no CR/LF.
6. Reset mid-frame: assert rst_n=0 during byte 3 → tx_valid drops asynchronously and no report_done; after release, report_req yields a complete frame starting with 0x66.
